// File: rtl/dac_pkg.sv
// Shared constants, code-word types and test-bus channel numbering for the DAC core model.
package dac_pkg;
  localparam int NBIN   = 7;
  localparam int NTHERM = 17;
  localparam int NATB   = 10;
  localparam int ICAL_W = 8;
  localparam int OUT_W  = 12;
  localparam int CNT_W  = $clog2(NTHERM + 1);
  localparam int FS     = NTHERM * (2 ** NBIN) + (2 ** NBIN) - 1;

  typedef logic        [OUT_W-1:0] code_t;
  typedef logic signed [OUT_W:0]   diff_t;

  typedef enum logic [3:0] {
    ATB_VOUT  = 4'd0,
    ATB_VOUTB = 4'd1,
    ATB_ICAL  = 4'd2,
    ATB_BIN   = 4'd3,
    ATB_CNT   = 4'd4,
    ATB_FLAGS = 4'd5
  } atb_ch_e;
endpackage

// File: rtl/dac_core_model_if.sv
// Sample-formatter side bus of the DAC core: data rails, calibration, test-bus control and results.
interface dac_core_model_if;
  import dac_pkg::*;

  logic        [NBIN-1:0]   datainbin;
  logic        [NBIN-1:0]   datainbinb;
  logic        [NTHERM-1:0] dataintherm;
  logic        [NTHERM-1:0] datainthermb;
  logic        [ICAL_W-1:0] dataical;
  logic        [NATB-1:0]   atb_ena;
  logic        [OUT_W-1:0]  vout;
  logic        [OUT_W-1:0]  voutb;
  logic signed [OUT_W:0]    vout_diff;
  logic        [ICAL_W-1:0] ical;
  logic        [OUT_W-1:0]  atb;
  logic                     atb_valid;
  logic                     comp_err;
  logic                     therm_err;

  modport master (
    output datainbin, datainbinb, dataintherm, datainthermb, dataical, atb_ena,
    input  vout, voutb, vout_diff, ical, atb, atb_valid, comp_err, therm_err
  );

  modport slave (
    input  datainbin, datainbinb, dataintherm, datainthermb, dataical, atb_ena,
    output vout, voutb, vout_diff, ical, atb, atb_valid, comp_err, therm_err
  );
endinterface

// File: rtl/dac_core_model_therm_decode.sv
// Thermometer segment decoder: counts enabled segments and flags codes that are not 0..01..1.
module therm_decode
  import dac_pkg::*;
(
  input  logic [NTHERM-1:0] therm,
  output logic [CNT_W-1:0]  cnt,
  output logic              err
);
  logic [NTHERM-1:0] therm_inc;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NTHERM; i++) cnt = cnt + CNT_W'(therm[i]);
  end

  // A contiguous run of ones from bit 0 turns to all zeros when incremented.
  assign therm_inc = therm + NTHERM'(1);
  assign err       = |(therm & therm_inc);
endmodule

// File: rtl/dac_core_model.sv
// Two-stage behavioural stand-in for the segmented current-steering DAC macro.
module dac_core_model
  import dac_pkg::*;
(
  input  logic clkin,
  input  logic clkinb,
  input  logic pdb,
  input  logic vddana_0p8,
  input  logic vddana_1p8,
  input  logic vssana,
  dac_core_model_if.slave bus
);
  logic [NBIN-1:0]   bin_p1;
  logic [NTHERM-1:0] therm_p1;
  logic [ICAL_W-1:0] ical_p1;
  logic [NATB-1:0]   atb_ena_p1;
  logic              comp_err_p1;

  code_t             vout_p2;
  code_t             voutb_p2;
  diff_t             vout_diff_p2;
  logic [ICAL_W-1:0] ical_p2;
  code_t             atb_p2;
  logic              atb_valid_p2;
  logic              comp_err_p2;
  logic              therm_err_p2;

  logic [CNT_W-1:0]  cnt;
  logic              therm_bad;
  code_t             code;
  code_t             code_b;
  diff_t             code_diff;
  logic [3:0]        atb_sel;
  logic              atb_hit;
  code_t             atb_d;
  logic              pwr_ok;
  logic              unused_clkinb;

  // The complementary clock rail exists only for pin compatibility.
  assign unused_clkinb = clkinb;
  assign pwr_ok        = vddana_0p8 & vddana_1p8 & ~vssana;

  // Stage 1: input capture and rail-complement check
  always_ff @(posedge clkin) begin
    if (!pdb) begin
      bin_p1      <= '0;
      therm_p1    <= '0;
      ical_p1     <= '0;
      atb_ena_p1  <= '0;
      comp_err_p1 <= 1'b0;
    end else begin
      bin_p1      <= bus.datainbin;
      therm_p1    <= bus.dataintherm;
      ical_p1     <= bus.dataical;
      atb_ena_p1  <= bus.atb_ena;
      comp_err_p1 <= |(bus.datainbin ^ ~bus.datainbinb) |
                     |(bus.dataintherm ^ ~bus.datainthermb);
    end
  end

  therm_decode u_therm_decode (
    .therm (therm_p1),
    .cnt   (cnt),
    .err   (therm_bad)
  );

  assign code      = (code_t'(cnt) << NBIN) | code_t'(bin_p1);
  assign code_b    = code_t'(FS) - code;
  assign code_diff = $signed({1'b0, code}) - $signed({1'b0, code_b});

  always_comb begin
    atb_sel = '0;
    atb_hit = 1'b0;
    for (int i = NATB - 1; i >= 0; i--) begin
      if (atb_ena_p1[i]) begin
        atb_sel = 4'(i);
        atb_hit = 1'b1;
      end
    end
    atb_d = '0;
    if (atb_hit) begin
      case (atb_sel)
        ATB_VOUT:  atb_d = code;
        ATB_VOUTB: atb_d = code_b;
        ATB_ICAL:  atb_d = code_t'(ical_p1);
        ATB_BIN:   atb_d = code_t'(bin_p1);
        ATB_CNT:   atb_d = code_t'(cnt);
        ATB_FLAGS: atb_d = code_t'({comp_err_p1, therm_bad});
        default:   atb_d = '0;
      endcase
    end
  end

  // Stage 2: output codes, test bus and aligned error flags
  always_ff @(posedge clkin) begin
    if (!pdb || !pwr_ok) begin
      vout_p2      <= '0;
      voutb_p2     <= '0;
      vout_diff_p2 <= '0;
      ical_p2      <= '0;
      atb_p2       <= '0;
      atb_valid_p2 <= 1'b0;
      comp_err_p2  <= 1'b0;
      therm_err_p2 <= 1'b0;
    end else begin
      vout_p2      <= code;
      voutb_p2     <= code_b;
      vout_diff_p2 <= code_diff;
      ical_p2      <= ical_p1;
      atb_p2       <= atb_d;
      atb_valid_p2 <= atb_hit;
      comp_err_p2  <= comp_err_p1;
      therm_err_p2 <= therm_bad;
    end
  end

  assign bus.vout      = vout_p2;
  assign bus.voutb     = voutb_p2;
  assign bus.vout_diff = vout_diff_p2;
  assign bus.ical      = ical_p2;
  assign bus.atb       = atb_p2;
  assign bus.atb_valid = atb_valid_p2;
  assign bus.comp_err  = comp_err_p2;
  assign bus.therm_err = therm_err_p2;
endmodule

// File: tb/tb_dac_core_model.sv
// Directed bench for dac_core_model: reset, power gating, code mapping, flags, test bus and a full ramp.
module tb_dac_core_model;
  logic clkin = 1'b0;
  logic clkinb;
  logic pdb;
  logic vddana_0p8;
  logic vddana_1p8;
  logic vssana;
  int   checks = 0;
  int   errors = 0;

  dac_core_model_if bus ();

  dac_core_model dut (
    .clkin      (clkin),
    .clkinb     (clkinb),
    .pdb        (pdb),
    .vddana_0p8 (vddana_0p8),
    .vddana_1p8 (vddana_1p8),
    .vssana     (vssana),
    .bus        (bus)
  );

  always #5 clkin = ~clkin;
  assign clkinb = ~clkin;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic put(input logic [6:0] b, input logic [16:0] t, input logic [7:0] c,
                     input logic [9:0] a, input logic [6:0] bflip);
    bus.datainbin    = b;
    bus.datainbinb   = ~b ^ bflip;
    bus.dataintherm  = t;
    bus.datainthermb = ~t;
    bus.dataical     = c;
    bus.atb_ena      = a;
  endtask

  function automatic logic [16:0] therm_of(input int n);
    return 17'((32'd1 << n) - 1);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vout"},  int'(bus.vout), 0);
    chk({tag, "_voutb"}, int'(bus.voutb), 0);
    chk({tag, "_diff"},  int'(bus.vout_diff), 0);
    chk({tag, "_ical"},  int'(bus.ical), 0);
    chk({tag, "_atb"},   int'(bus.atb), 0);
    chk({tag, "_atbv"},  int'(bus.atb_valid), 0);
    chk({tag, "_cerr"},  int'(bus.comp_err), 0);
    chk({tag, "_terr"},  int'(bus.therm_err), 0);
  endtask

  initial begin
    pdb        = 1'b0;
    vddana_0p8 = 1'b1;
    vddana_1p8 = 1'b1;
    vssana     = 1'b0;
    put(7'd0, 17'd0, 8'd0, 10'd0, 7'd0);

    // Reset with random data
    for (int i = 0; i < 3; i++) begin
      put(7'($urandom), 17'($urandom), 8'($urandom), 10'($urandom), 7'($urandom));
      step();
    end
    chk_all_zero("reset");

    // Released but ground flag bad: stage 2 stays cleared
    pdb    = 1'b1;
    vssana = 1'b1;
    put(7'h7F, therm_of(8), 8'h33, 10'h001, 7'd0);
    repeat (3) step();
    chk_all_zero("pwrgate");
    vssana = 1'b0;

    // Midscale
    put(7'h7F, 17'h000FF, 8'h00, 10'd0, 7'd0);
    repeat (2) step();
    chk("mid_vout",  int'(bus.vout), 1151);
    chk("mid_voutb", int'(bus.voutb), 1152);
    chk("mid_diff",  int'(bus.vout_diff), -1);
    chk("mid_cerr",  int'(bus.comp_err), 0);
    chk("mid_terr",  int'(bus.therm_err), 0);

    // Full scale
    put(7'd127, 17'h1FFFF, 8'h00, 10'd0, 7'd0);
    repeat (2) step();
    chk("fs_vout",  int'(bus.vout), 2303);
    chk("fs_voutb", int'(bus.voutb), 0);
    chk("fs_diff",  int'(bus.vout_diff), 2303);

    // Zero
    put(7'd0, 17'd0, 8'h00, 10'd0, 7'd0);
    repeat (2) step();
    chk("zero_vout",  int'(bus.vout), 0);
    chk("zero_voutb", int'(bus.voutb), 2303);
    chk("zero_diff",  int'(bus.vout_diff), -2303);

    // Single bad complement sample in a stream: A good, B bad, C good
    put(7'd1, therm_of(1), 8'h00, 10'd0, 7'd0);
    step();
    put(7'd20, therm_of(3), 8'h00, 10'd0, 7'h08);
    step();
    chk("cmp_a_cerr", int'(bus.comp_err), 0);
    chk("cmp_a_vout", int'(bus.vout), 129);
    put(7'd5, therm_of(2), 8'h00, 10'd0, 7'd0);
    step();
    chk("cmp_b_cerr", int'(bus.comp_err), 1);
    chk("cmp_b_vout", int'(bus.vout), 404);
    step();
    chk("cmp_c_cerr", int'(bus.comp_err), 0);
    chk("cmp_c_vout", int'(bus.vout), 261);

    // Non-contiguous thermometer, also observed on the flags channel
    put(7'd10, 17'h00005, 8'h00, 10'b0000100000, 7'd0);
    repeat (2) step();
    chk("therm_terr", int'(bus.therm_err), 1);
    chk("therm_vout", int'(bus.vout), 266);
    chk("therm_atb",  int'(bus.atb), 1);
    chk("therm_atbv", int'(bus.atb_valid), 1);

    // Test bus: calibration channel
    put(7'd10, therm_of(4), 8'hA5, 10'b0000000100, 7'd0);
    repeat (2) step();
    chk("atb_ical",  int'(bus.atb), 'h0A5);
    chk("atb_icalv", int'(bus.atb_valid), 1);
    chk("ical_out",  int'(bus.ical), 'hA5);

    // Test bus: nothing enabled
    put(7'd10, therm_of(4), 8'hA5, 10'd0, 7'd0);
    repeat (2) step();
    chk("atb_none",  int'(bus.atb), 0);
    chk("atb_nonev", int'(bus.atb_valid), 0);

    // Priority: bits 1 and 4 set, voutb wins
    put(7'h7F, therm_of(8), 8'h00, 10'b0000010010, 7'd0);
    repeat (2) step();
    chk("atb_prio", int'(bus.atb), 1152);

    // Count and binary channels, reserved channel
    put(7'd77, therm_of(9), 8'h00, 10'b0000010000, 7'd0);
    repeat (2) step();
    chk("atb_cnt", int'(bus.atb), 9);
    put(7'd77, therm_of(9), 8'h00, 10'b0000001000, 7'd0);
    repeat (2) step();
    chk("atb_bin", int'(bus.atb), 77);
    put(7'd77, therm_of(9), 8'h00, 10'b1001000000, 7'd0);
    repeat (2) step();
    chk("atb_rsvd",  int'(bus.atb), 0);
    chk("atb_rsvdv", int'(bus.atb_valid), 1);

    // Streaming ramp 0..FS, output trails input by two edges
    for (int i = 0; i <= 2304; i++) begin
      int c;
      c = (i <= 2303) ? i : 0;
      put(7'(c % 128), therm_of(c / 128), 8'h00, 10'd0, 7'd0);
      step();
      if (i >= 1) begin
        chk("ramp_vout",  int'(bus.vout), i - 1);
        chk("ramp_voutb", int'(bus.voutb), 2303 - (i - 1));
        chk("ramp_cerr",  int'(bus.comp_err), 0);
        chk("ramp_terr",  int'(bus.therm_err), 0);
      end
    end

    // Mid-stream reset discards in-flight samples
    put(7'd50, therm_of(6), 8'h12, 10'd1, 7'd0);
    step();
    pdb = 1'b0;
    step();
    chk("midrst_vout",  int'(bus.vout), 0);
    chk("midrst_voutb", int'(bus.voutb), 0);
    chk("midrst_ical",  int'(bus.ical), 0);
    pdb = 1'b1;
    repeat (2) step();
    chk("post_rst_vout", int'(bus.vout), 818);
    chk("post_rst_atb",  int'(bus.atb), 818);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got %0d exp %0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
